// File: rtl/convolution_result_streamer.sv
// Buffers the Z results a convolution run writes, then replays them in address
// order 0..count-1 over a valid/ready stream once the processor signals done.
module convolution_result_streamer #(
  parameter int unsigned DATA_WIDTH_DATAZ     = 16,
  parameter int unsigned DATA_WIDTH_MEMZ_ADDR = 6
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            busy_i,
  input  logic                            done_i,
  input  logic                            writeZ_i,
  input  logic [DATA_WIDTH_MEMZ_ADDR-1:0] memZ_addr_i,
  input  logic [DATA_WIDTH_DATAZ-1:0]     dataZ_i,
  output logic [DATA_WIDTH_DATAZ-1:0]     stream_data_o,
  output logic [DATA_WIDTH_MEMZ_ADDR-1:0] stream_index_o,
  output logic                            stream_valid_o,
  output logic                            stream_last_o,
  input  logic                            stream_ready_i,
  output logic [DATA_WIDTH_MEMZ_ADDR:0]   count_o,
  output logic                            ready_o,
  output logic                            overrun_o
);

  localparam int unsigned Dw    = DATA_WIDTH_DATAZ;
  localparam int unsigned Aw    = DATA_WIDTH_MEMZ_ADDR;
  localparam int unsigned Depth = 2 ** Aw;
  localparam logic [Aw:0] CntOne = (Aw + 1)'(1);
  localparam logic [Aw:0] CntTwo = (Aw + 1)'(2);
  localparam logic [Aw-1:0] IdxOne = Aw'(1);

  typedef enum logic [1:0] {StIdle, StCapture, StLoad, StStream} state_e;

  state_e           state_q, state_d;
  logic [Dw-1:0]    mem_q [Depth];
  logic [Depth-1:0] written_q, written_d;
  logic [Dw-1:0]    data_q, data_d;
  logic [Aw-1:0]    index_q, index_d;
  logic             valid_q, valid_d;
  logic             last_q, last_d;
  logic [Aw:0]      count_q, count_d;
  logic             overrun_q, overrun_d;
  logic             busy_q;

  logic             mem_we;
  logic             busy_rise;
  logic [Aw:0]      wr_count;
  logic [Aw-1:0]    next_idx;
  logic [Aw-1:0]    rd_addr;
  logic [Dw-1:0]    rd_data;

  assign busy_rise = busy_i & ~busy_q;
  assign wr_count  = {1'b0, memZ_addr_i} + CntOne;
  assign next_idx  = index_q + IdxOne;
  // Entries not written during this run read as zero, so the array never needs clearing.
  assign rd_data   = written_q[rd_addr] ? mem_q[rd_addr] : '0;

  always_comb begin
    state_d   = state_q;
    written_d = written_q;
    data_d    = data_q;
    index_d   = index_q;
    valid_d   = valid_q;
    last_d    = last_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    mem_we    = 1'b0;
    rd_addr   = next_idx;

    case (state_q)
      StIdle: begin
        if (busy_i) begin
          state_d   = StCapture;
          written_d = '0;
          count_d   = '0;
          overrun_d = 1'b0;
        end else if (writeZ_i) begin
          overrun_d = 1'b1;
        end
      end

      StCapture: begin
        if (writeZ_i) begin
          mem_we                 = 1'b1;
          written_d[memZ_addr_i] = 1'b1;
          if (wr_count > count_q) begin
            count_d = wr_count;
          end
        end
        // A write in the done cycle is already folded into count_d here.
        if (done_i) begin
          state_d = (count_d != '0) ? StLoad : StIdle;
        end
      end

      StLoad: begin
        rd_addr = '0;
        data_d  = rd_data;
        index_d = '0;
        valid_d = 1'b1;
        last_d  = (count_q == CntOne);
        state_d = StStream;
        if (writeZ_i || busy_rise) begin
          overrun_d = 1'b1;
        end
      end

      StStream: begin
        if (writeZ_i || busy_rise) begin
          overrun_d = 1'b1;
        end
        if (valid_q && stream_ready_i) begin
          if (last_q) begin
            valid_d = 1'b0;
            last_d  = 1'b0;
            state_d = StIdle;
          end else begin
            index_d = next_idx;
            data_d  = rd_data;
            last_d  = (({1'b0, index_q} + CntTwo) == count_q);
          end
        end
      end

      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StIdle;
      written_q <= '0;
      data_q    <= '0;
      index_q   <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      written_q <= written_d;
      data_q    <= data_d;
      index_q   <= index_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      busy_q    <= busy_i;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[memZ_addr_i] <= dataZ_i;
    end
  end

  assign stream_data_o  = data_q;
  assign stream_index_o = index_q;
  assign stream_valid_o = valid_q;
  assign stream_last_o  = last_q;
  assign count_o        = count_q;
  assign overrun_o      = overrun_q;
  assign ready_o        = (state_q == StIdle);

endmodule

// File: tb/tb_convolution_result_streamer.sv
// Bench for convolution_result_streamer: scenario tasks checked against an
// address-indexed model of the result buffer and the stream it should produce.
module tb_convolution_result_streamer;

  localparam int Dw    = 16;
  localparam int Aw    = 6;
  localparam int Depth = 64;

  logic          clk = 1'b0;
  logic          rst;
  logic          busy_i, done_i, writeZ_i, stream_ready_i;
  logic [Aw-1:0] memZ_addr_i;
  logic [Dw-1:0] dataZ_i;
  logic [Dw-1:0] stream_data_o;
  logic [Aw-1:0] stream_index_o;
  logic          stream_valid_o, stream_last_o;
  logic [Aw:0]   count_o;
  logic          ready_o, overrun_o;

  convolution_result_streamer #(
    .DATA_WIDTH_DATAZ    (Dw),
    .DATA_WIDTH_MEMZ_ADDR(Aw)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .busy_i        (busy_i),
    .done_i        (done_i),
    .writeZ_i      (writeZ_i),
    .memZ_addr_i   (memZ_addr_i),
    .dataZ_i       (dataZ_i),
    .stream_data_o (stream_data_o),
    .stream_index_o(stream_index_o),
    .stream_valid_o(stream_valid_o),
    .stream_last_o (stream_last_o),
    .stream_ready_i(stream_ready_i),
    .count_o       (count_o),
    .ready_o       (ready_o),
    .overrun_o     (overrun_o)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  // Model: what each address holds this run and the run's sample count.
  logic [Dw-1:0] m_mem [Depth];
  bit            m_wr  [Depth];
  int            m_count;

  logic [Dw-1:0] got_data [$];
  int            got_idx  [$];
  bit            got_last [$];
  int            unstable;
  int            iters;
  bit            timed_out;

  function automatic logic [Dw-1:0] m_entry(input int i);
    return m_wr[i] ? m_mem[i] : '0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < Depth; i++) m_wr[i] = 1'b0;
    m_count = 0;
  endtask

  task automatic model_write(input int a, input logic [Dw-1:0] d);
    m_mem[a] = d;
    m_wr[a]  = 1'b1;
    if (a + 1 > m_count) m_count = a + 1;
  endtask

  // All stimulus tasks start and end just after a falling edge.
  task automatic start_run();
    busy_i = 1'b1;
    @(negedge clk);
    model_clear();
  endtask

  task automatic write_z(input int a, input logic [Dw-1:0] d);
    writeZ_i    = 1'b1;
    memZ_addr_i = Aw'(a);
    dataZ_i     = d;
    model_write(a, d);
    @(negedge clk);
    writeZ_i = 1'b0;
  endtask

  task automatic end_run(input bit with_wr, input int a, input logic [Dw-1:0] d);
    done_i = 1'b1;
    busy_i = 1'b0;
    if (with_wr) begin
      writeZ_i    = 1'b1;
      memZ_addr_i = Aw'(a);
      dataZ_i     = d;
      model_write(a, d);
    end
    @(negedge clk);
    done_i   = 1'b0;
    writeZ_i = 1'b0;
  endtask

  // mode 0: ready high, 1: fixed 0,1,0,0,1,1 pattern, 2: random ready.
  task automatic collect(input int mode, input int budget);
    bit            pat [6] = '{0, 1, 0, 0, 1, 1};
    bit            r, hold, fin;
    logic [Dw-1:0] hd;
    logic [Aw-1:0] hi;
    logic          hl;
    int            k;
    got_data.delete();
    got_idx.delete();
    got_last.delete();
    unstable  = 0;
    timed_out = 1'b1;
    hold      = 1'b0;
    k         = 0;
    iters     = 0;
    for (int c = 0; c < budget; c++) begin
      iters++;
      if (hold && (stream_valid_o !== 1'b1 || stream_data_o !== hd ||
                   stream_index_o !== hi || stream_last_o !== hl)) unstable++;
      if (mode == 0) r = 1'b1;
      else if (mode == 1) r = stream_valid_o ? pat[k % 6] : 1'b0;
      else r = 1'($urandom_range(0, 1));
      if (stream_valid_o) k++;
      stream_ready_i = r;
      hold = stream_valid_o && !r;
      hd   = stream_data_o;
      hi   = stream_index_o;
      hl   = stream_last_o;
      fin  = 1'b0;
      if (stream_valid_o && r) begin
        got_data.push_back(stream_data_o);
        got_idx.push_back(int'(stream_index_o));
        got_last.push_back(stream_last_o);
        fin = stream_last_o;
      end
      @(negedge clk);
      if (fin) begin
        timed_out = 1'b0;
        break;
      end
    end
    stream_ready_i = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; busy_i = 0; done_i = 0; writeZ_i = 0; stream_ready_i = 0;
    memZ_addr_i = '0; dataZ_i = '0;
    repeat (2) @(negedge clk);
    n_tests++; if (stream_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", stream_valid_o); end
    n_tests++; if (stream_last_o !== 1'b0) begin n_fail++; $display("FAIL reset_last: got %b want 0", stream_last_o); end
    n_tests++; if (stream_data_o !== '0 || stream_index_o !== '0) begin n_fail++; $display("FAIL reset_data_idx: got %h/%0d want 0/0", stream_data_o, stream_index_o); end
    n_tests++; if (count_o !== '0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count_o); end
    n_tests++; if (ready_o !== 1'b1 || overrun_o !== 1'b0) begin n_fail++; $display("FAIL reset_ready_ovr: got %b/%b want 1/0", ready_o, overrun_o); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    start_run();
    write_z(0, 16'd5); write_z(1, 16'd7); write_z(2, 16'd9);
    end_run(0, 0, '0);
    n_tests++; if (count_o !== 7'(m_count)) begin n_fail++; $display("FAIL basic_count: got %0d want %0d", count_o, m_count); end
    n_tests++; if (stream_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_latency1: valid got %b want 0", stream_valid_o); end
    @(negedge clk);
    n_tests++; if (stream_valid_o !== 1'b1) begin n_fail++; $display("FAIL basic_latency2: valid got %b want 1", stream_valid_o); end
    collect(0, 20);
    n_tests++; if (timed_out || got_data.size() != m_count) begin n_fail++; $display("FAIL basic_len: got %0d want %0d", got_data.size(), m_count); end
    n_tests++; if (iters != m_count) begin n_fail++; $display("FAIL basic_rate: cycles got %0d want %0d", iters, m_count); end
    for (int i = 0; i < m_count && i < got_data.size(); i++) begin
      n_tests++;
      if (got_data[i] !== m_entry(i) || got_idx[i] != i || got_last[i] != (i == m_count - 1)) begin
        n_fail++; $display("FAIL basic_sample%0d: got %h/%0d/%b want %h/%0d/%b", i, got_data[i],
                            got_idx[i], got_last[i], m_entry(i), i, i == m_count - 1);
      end
    end
    n_tests++; if (ready_o !== 1'b1 || stream_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_idle: ready/valid got %b/%b want 1/0", ready_o, stream_valid_o); end
  endtask

  task automatic test_backpressure();
    start_run();
    write_z(0, 16'd5); write_z(1, 16'd7); write_z(2, 16'd9);
    end_run(0, 0, '0);
    collect(1, 40);
    n_tests++; if (timed_out || got_data.size() != 3) begin n_fail++; $display("FAIL bp_len: got %0d want 3", got_data.size()); end
    n_tests++; if (unstable != 0) begin n_fail++; $display("FAIL bp_stable: changes under stall got %0d want 0", unstable); end
    for (int i = 0; i < m_count && i < got_data.size(); i++) begin
      n_tests++;
      if (got_data[i] !== m_entry(i) || got_idx[i] != i || got_last[i] != (i == m_count - 1)) begin
        n_fail++; $display("FAIL bp_sample%0d: got %h/%0d/%b want %h/%0d/%b", i, got_data[i],
                            got_idx[i], got_last[i], m_entry(i), i, i == m_count - 1);
      end
    end
  endtask

  task automatic test_sparse();
    start_run();
    write_z(3, 16'h1234); write_z(0, 16'h0011);
    end_run(0, 0, '0);
    n_tests++; if (count_o !== 7'd4) begin n_fail++; $display("FAIL sparse_count: got %0d want 4", count_o); end
    collect(0, 20);
    n_tests++; if (timed_out || got_data.size() != m_count) begin n_fail++; $display("FAIL sparse_len: got %0d want %0d", got_data.size(), m_count); end
    for (int i = 0; i < m_count && i < got_data.size(); i++) begin
      n_tests++;
      if (got_data[i] !== m_entry(i) || got_idx[i] != i || got_last[i] != (i == m_count - 1)) begin
        n_fail++; $display("FAIL sparse_sample%0d: got %h/%0d/%b want %h/%0d/%b", i, got_data[i],
                            got_idx[i], got_last[i], m_entry(i), i, i == m_count - 1);
      end
    end
  endtask

  task automatic test_empty();
    int seen = 0;
    start_run();
    end_run(0, 0, '0);
    stream_ready_i = 1'b1;
    for (int c = 0; c < 6; c++) begin
      if (stream_valid_o !== 1'b0) seen++;
      @(negedge clk);
    end
    stream_ready_i = 1'b0;
    n_tests++; if (seen != 0) begin n_fail++; $display("FAIL empty_valid: valid cycles got %0d want 0", seen); end
    n_tests++; if (count_o !== '0 || ready_o !== 1'b1) begin n_fail++; $display("FAIL empty_idle: count/ready got %0d/%b want 0/1", count_o, ready_o); end
  endtask

  task automatic test_overrun();
    start_run();
    write_z(0, 16'h0A0A); write_z(1, 16'h0B0B); write_z(2, 16'h0C0C);
    end_run(0, 0, '0);
    @(negedge clk);
    // Stray write while streaming; the model deliberately does not absorb it.
    writeZ_i = 1'b1; memZ_addr_i = 6'd1; dataZ_i = 16'hFFFF;
    @(negedge clk);
    writeZ_i = 1'b0;
    n_tests++; if (overrun_o !== 1'b1) begin n_fail++; $display("FAIL ovr_set: got %b want 1", overrun_o); end
    collect(0, 20);
    n_tests++; if (timed_out || got_data.size() != m_count) begin n_fail++; $display("FAIL ovr_len: got %0d want %0d", got_data.size(), m_count); end
    for (int i = 0; i < m_count && i < got_data.size(); i++) begin
      n_tests++;
      if (got_data[i] !== m_entry(i) || got_idx[i] != i) begin
        n_fail++; $display("FAIL ovr_sample%0d: got %h/%0d want %h/%0d", i, got_data[i], got_idx[i], m_entry(i), i);
      end
    end
    n_tests++; if (overrun_o !== 1'b1) begin n_fail++; $display("FAIL ovr_sticky: got %b want 1", overrun_o); end
    start_run();
    n_tests++; if (overrun_o !== 1'b0) begin n_fail++; $display("FAIL ovr_clear: got %b want 0", overrun_o); end
    end_run(0, 0, '0);
    @(negedge clk);
  endtask

  task automatic test_boundary_reset();
    bit found = 1'b0;
    start_run();
    write_z(63, 16'hABCD);
    end_run(0, 0, '0);
    n_tests++; if (count_o !== 7'd64) begin n_fail++; $display("FAIL bnd_count: got %0d want 64", count_o); end
    collect(0, 100);
    n_tests++; if (timed_out || got_data.size() != 64) begin n_fail++; $display("FAIL bnd_len: got %0d want 64", got_data.size()); end
    for (int i = 0; i < m_count && i < got_data.size(); i++) begin
      n_tests++;
      if (got_data[i] !== m_entry(i) || got_idx[i] != i || got_last[i] != (i == 63)) begin
        n_fail++; $display("FAIL bnd_sample%0d: got %h/%0d/%b want %h/%0d/%b", i, got_data[i],
                            got_idx[i], got_last[i], m_entry(i), i, i == 63);
      end
    end
    start_run();
    write_z(63, 16'hABCD);
    end_run(0, 0, '0);
    stream_ready_i = 1'b1;
    for (int c = 0; c < 40; c++) begin
      if (stream_valid_o === 1'b1 && stream_index_o === 6'd10) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    n_tests++; if (!found) begin n_fail++; $display("FAIL rst_reach_idx10: got timeout want index 10"); end
    rst = 1'b1;
    #1;
    n_tests++; if (stream_valid_o !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", stream_valid_o); end
    n_tests++; if (count_o !== '0 || ready_o !== 1'b1) begin n_fail++; $display("FAIL rst_state: count/ready got %0d/%b want 0/1", count_o, ready_o); end
    stream_ready_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    for (int run = 0; run < 8; run++) begin
      int nw;
      start_run();
      nw = $urandom_range(1, 12);
      for (int w = 0; w < nw; w++) begin
        write_z(run[0] ? $urandom_range(0, 63) : $urandom_range(0, 15), 16'($urandom));
      end
      end_run(1'($urandom_range(0, 1)), $urandom_range(0, 20), 16'($urandom));
      n_tests++; if (count_o !== 7'(m_count)) begin n_fail++; $display("FAIL rnd%0d_count: got %0d want %0d", run, count_o, m_count); end
      collect(2, 500);
      n_tests++; if (timed_out || got_data.size() != m_count) begin n_fail++; $display("FAIL rnd%0d_len: got %0d want %0d", run, got_data.size(), m_count); end
      for (int i = 0; i < m_count && i < got_data.size(); i++) begin
        n_tests++;
        if (got_data[i] !== m_entry(i) || got_idx[i] != i || got_last[i] != (i == m_count - 1)) begin
          n_fail++; $display("FAIL rnd%0d_sample%0d: got %h/%0d/%b want %h/%0d/%b", run, i, got_data[i],
                              got_idx[i], got_last[i], m_entry(i), i, i == m_count - 1);
        end
      end
      n_tests++; if (unstable != 0 || ready_o !== 1'b1 || overrun_o !== 1'b0) begin
        n_fail++; $display("FAIL rnd%0d_end: unstable/ready/ovr got %0d/%b/%b want 0/1/0", run, unstable, ready_o, overrun_o);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_sparse();
    test_empty();
    test_overrun();
    test_boundary_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got time limit want completion");
    $fatal(1, "watchdog");
  end

endmodule
